// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction-ROM fetch arbiter: slot owner encoding,
// default reset PC and the response-stage record.
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DBG   = 2'd2
  } owner_t;

  // Byte-PC width for the default 14-bit word-addressed ROM.
  localparam int unsigned FETCH_PC_W = 16;
  localparam logic [FETCH_PC_W-1:0] RESET_PC_DEF = 16'h0000;

  // What was issued to the ROM last cycle, so its data can be routed.
  typedef struct packed {
    owner_t                  owner;
    logic [FETCH_PC_W-1:0]   pc;
    logic                    epoch;
  } rsp_t;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// ROM, decode and debug-port signal bundle for imem_fetch_arbiter.
// master = the arbiter, slave = ROM wrapper / decode / debug side.
interface imem_fetch_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int PC_W = ADDR_W + 2;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output rom_addr, input rom_dout,
    output inst, inst_pc, inst_valid, input inst_ready,
    input  redirect_en, redirect_pc,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  rom_addr, output rom_dout,
    input  inst, inst_pc, inst_valid, output inst_ready,
    output redirect_en, redirect_pc,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata
  );
endinterface

// File: rtl/imem_skid_buf.sv
// Two-entry FIFO (output register + skid register) between the ROM response
// stage and decode. Upstream guarantees it never pushes into a full skid.
module imem_skid_buf #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         skid_full
);

  logic [W-1:0] skid_data;

  // Output register refills from skid first, then from the input, else clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_full) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        skid_full <= in_valid;
        if (in_valid) skid_data <= in_data;
      end else if (in_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end
    end else if (in_valid) begin
      skid_full <= 1'b1;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Fetch sequencer / arbiter for the synchronous-read program ROM.
// Shares one ROM read slot per cycle between the CPU fetch stream and a debug
// read port, absorbs decode backpressure in a 2-entry skid buffer and handles
// redirects via an epoch bit.
// Optional feature macro: FETCH_PERF_EN (adds consumed/stall counters).
module imem_fetch_arbiter
  import imem_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 14,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W+1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  imem_fetch_arbiter_if.master    bus,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt
);

  localparam int PC_W = ADDR_W + 2;

  logic [PC_W-1:0]        pc;
  logic [PC_W-1:0]        issue_pc;
  rsp_t                   rsp;
  logic                   epoch;
  owner_t                 last_winner;
  owner_t                 winner;
  logic                   consume;
  logic                   rsp_is_fetch;
  logic                   fetch_elig;
  logic                   tie;
  logic [1:0]             occ;
  logic [1:0]             occ_left;
  logic                   out_full;
  logic                   skid_full;
  logic                   skid_in_valid;
  logic [DATA_W+PC_W-1:0] skid_out;

  // Slot eligibility, round-robin arbitration and ROM address mux.
  always_comb begin
    consume      = bus.inst_valid && bus.inst_ready;
    rsp_is_fetch = (rsp.owner == OWN_FETCH);
    occ          = 2'(out_full) + 2'(skid_full) + 2'(rsp_is_fetch);
    occ_left     = occ - 2'(consume);
    // A redirect empties the pipeline this cycle, so fetch is always eligible.
    fetch_elig   = bus.redirect_en || (occ_left < 2'd2);
    issue_pc     = bus.redirect_en ? (bus.redirect_pc & ~PC_W'(3)) : pc;
    tie          = fetch_elig && bus.dbg_req;
    winner       = OWN_NONE;
    if (!rst) begin
      if (tie)             winner = (last_winner == OWN_DBG) ? OWN_FETCH : OWN_DBG;
      else if (fetch_elig) winner = OWN_FETCH;
      else if (bus.dbg_req) winner = OWN_DBG;
    end
    bus.rom_addr = (winner == OWN_DBG) ? bus.dbg_addr : issue_pc[PC_W-1:2];
    bus.dbg_gnt  = (winner == OWN_DBG);
  end

  // PC, epoch, response-stage record and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp         <= '{owner: OWN_NONE, pc: '0, epoch: 1'b0};
      epoch       <= 1'b0;
      last_winner <= OWN_DBG;
    end else begin
      epoch <= epoch ^ bus.redirect_en;
      if (winner == OWN_FETCH)   pc <= issue_pc + PC_W'(4);
      else if (bus.redirect_en)  pc <= issue_pc;
      rsp.owner <= winner;
      rsp.pc    <= issue_pc;
      rsp.epoch <= epoch ^ bus.redirect_en;
      if (tie) last_winner <= winner;
    end
  end

  // The epoch still matches during the redirect cycle itself (it toggles at the
  // edge), so the in-flight fetch response is dropped explicitly there.
  always_comb begin
    skid_in_valid = rsp_is_fetch && (rsp.epoch == epoch) && !bus.redirect_en;
  end

  imem_skid_buf #(
    .W (DATA_W + PC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_en),
    .in_valid  (skid_in_valid),
    .in_data   ({bus.rom_dout, rsp.pc}),
    .out_valid (out_full),
    .out_data  (skid_out),
    .out_ready (bus.inst_ready),
    .skid_full (skid_full)
  );

  // Decode outputs come straight from the output register; debug data is the
  // ROM word of the cycle whose response stage belongs to the debug port.
  always_comb begin
    bus.inst_valid = out_full;
    bus.inst       = skid_out[DATA_W+PC_W-1:PC_W];
    bus.inst_pc    = skid_out[PC_W-1:0];
    bus.dbg_rvalid = (rsp.owner == OWN_DBG);
    bus.dbg_rdata  = bus.dbg_rvalid ? bus.rom_dout : '0;
  end

`ifdef FETCH_PERF_EN
  // Saturating counts of consumed instructions and decode-stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (consume && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bus.inst_valid && !bus.inst_ready && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Counters not built: ports tie off.
  always_comb begin
    perf_fetch_cnt = '0;
    perf_stall_cnt = '0;
  end
`endif

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed self-checking bench for imem_fetch_arbiter. ROM word i holds i.
module tb_imem_fetch_arbiter;
  logic        clk;
  logic        rst;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  int          n_cmp;
  int          n_err;

  imem_fetch_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

  imem_fetch_arbiter #(
    .ADDR_W   (14),
    .DATA_W   (32),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM, word i = i.
  always @(posedge clk) bus.rom_dout <= {18'b0, bus.rom_addr};

  task next_cyc;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst = 1'b1;
    bus.inst_ready  = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.dbg_req     = 1'b0;
    bus.dbg_addr    = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst = 1'b1;
    bus.inst_ready  = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.dbg_req     = 1'b1;
    bus.dbg_addr    = 14'h2AAA;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %b exp 0", bus.inst_valid); end
    n_cmp++; if (bus.inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h exp 0", bus.inst); end
    n_cmp++; if (bus.inst_pc !== 16'h0) begin n_err++; $display("FAIL reset_inst_pc got %h exp 0", bus.inst_pc); end
    n_cmp++; if (bus.dbg_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dbg_gnt got %b exp 0", bus.dbg_gnt); end
    n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_dbg_rvalid got %b exp 0", bus.dbg_rvalid); end
    n_cmp++; if (bus.dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dbg_rdata got %h exp 0", bus.dbg_rdata); end
    n_cmp++; if (bus.rom_addr !== 14'h0) begin n_err++; $display("FAIL reset_rom_addr got %h exp 0", bus.rom_addr); end
`ifndef FETCH_PERF_EN
    n_cmp++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
      n_err++; $display("FAIL reset_perf got %h/%h exp 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    bus.dbg_req = 1'b0;
  endtask

  task test_stream;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      rst = 1'b0;
      bus.inst_ready = 1'b1;
      #1;
      n_cmp++; if (bus.rom_addr !== 14'(c)) begin n_err++; $display("FAIL stream_rom_addr c=%0d got %h exp %h", c, bus.rom_addr, 14'(c)); end
      n_cmp++; if (bus.inst_valid !== (c >= 2)) begin n_err++; $display("FAIL stream_inst_valid c=%0d got %b exp %b", c, bus.inst_valid, (c >= 2)); end
      if (c >= 2) begin
        n_cmp++; if (bus.inst_pc !== 16'(4 * (c - 2))) begin n_err++; $display("FAIL stream_inst_pc c=%0d got %h exp %h", c, bus.inst_pc, 16'(4 * (c - 2))); end
        n_cmp++; if (bus.inst !== 32'(c - 2)) begin n_err++; $display("FAIL stream_inst c=%0d got %h exp %h", c, bus.inst, 32'(c - 2)); end
      end
      next_cyc();
    end
  endtask

  task test_stall;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      rst = 1'b0;
      bus.inst_ready = !(c >= 6 && c <= 8);
      #1;
      if (c >= 6 && c <= 8) begin
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0010) begin n_err++; $display("FAIL stall_hold c=%0d got v=%b pc=%h exp v=1 pc=0010", c, bus.inst_valid, bus.inst_pc); end
        n_cmp++; if (bus.rom_addr !== 14'd6) begin n_err++; $display("FAIL stall_rom_freeze c=%0d got %h exp 6", c, bus.rom_addr); end
      end
      if (c >= 9) begin
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'(16'h10 + 4 * (c - 9))) begin n_err++; $display("FAIL stall_resume_pc c=%0d got v=%b pc=%h exp %h", c, bus.inst_valid, bus.inst_pc, 16'(16'h10 + 4 * (c - 9))); end
        n_cmp++; if (bus.inst !== 32'(4 + c - 9)) begin n_err++; $display("FAIL stall_resume_inst c=%0d got %h exp %h", c, bus.inst, 32'(4 + c - 9)); end
        n_cmp++; if (bus.rom_addr !== 14'(6 + c - 9)) begin n_err++; $display("FAIL stall_resume_rom c=%0d got %h exp %h", c, bus.rom_addr, 14'(6 + c - 9)); end
      end
      next_cyc();
    end
  endtask

  task test_redirect;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      rst = 1'b0;
      bus.inst_ready  = !(c >= 6 && c <= 9);
      bus.redirect_en = (c == 7);
      bus.redirect_pc = 16'h0043;
      #1;
      case (c)
        7: begin
          n_cmp++; if (bus.rom_addr !== 14'h10) begin n_err++; $display("FAIL redir_issue_rom got %h exp 10", bus.rom_addr); end
        end
        8: begin
          n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush_valid got %b exp 0", bus.inst_valid); end
          n_cmp++; if (bus.rom_addr !== 14'h11) begin n_err++; $display("FAIL redir_next_rom got %h exp 11", bus.rom_addr); end
        end
        9, 10: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0040 || bus.inst !== 32'd16) begin
            n_err++; $display("FAIL redir_first c=%0d got v=%b pc=%h inst=%h exp v=1 pc=0040 inst=10", c, bus.inst_valid, bus.inst_pc, bus.inst);
          end
        end
        11, 12: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'(16'h44 + 4 * (c - 11)) || bus.inst !== 32'(17 + c - 11)) begin
            n_err++; $display("FAIL redir_follow c=%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h", c, bus.inst_valid, bus.inst_pc, bus.inst, 16'(16'h44 + 4 * (c - 11)), 32'(17 + c - 11));
          end
        end
        default: ;
      endcase
      next_cyc();
    end
    bus.redirect_en = 1'b0;
  endtask

  task test_dbg;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      rst = 1'b0;
      bus.inst_ready = 1'b1;
      bus.dbg_req    = (c >= 3 && c <= 4) || (c >= 8 && c <= 11);
      bus.dbg_addr   = 14'h1234;
      #1;
      case (c)
        3: begin
          n_cmp++; if (bus.dbg_gnt !== 1'b0 || bus.rom_addr !== 14'd3) begin n_err++; $display("FAIL dbg_first_tie got gnt=%b rom=%h exp gnt=0 rom=3", bus.dbg_gnt, bus.rom_addr); end
        end
        4: begin
          n_cmp++; if (bus.dbg_gnt !== 1'b1 || bus.rom_addr !== 14'h1234) begin n_err++; $display("FAIL dbg_gnt got gnt=%b rom=%h exp gnt=1 rom=1234", bus.dbg_gnt, bus.rom_addr); end
          n_cmp++; if (bus.dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dbg_rvalid_early got %b exp 0", bus.dbg_rvalid); end
        end
        5: begin
          n_cmp++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'h1234) begin n_err++; $display("FAIL dbg_rdata got v=%b d=%h exp v=1 d=1234", bus.dbg_rvalid, bus.dbg_rdata); end
          n_cmp++; if (bus.dbg_gnt !== 1'b0 || bus.rom_addr !== 14'd4) begin n_err++; $display("FAIL dbg_fetch_resume got gnt=%b rom=%h exp gnt=0 rom=4", bus.dbg_gnt, bus.rom_addr); end
          n_cmp++; if (bus.inst_pc !== 16'h000C) begin n_err++; $display("FAIL dbg_stream_pc got %h exp 000c", bus.inst_pc); end
        end
        6: begin
          n_cmp++; if (bus.inst_valid !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL dbg_bubble got v=%b rv=%b exp 0/0", bus.inst_valid, bus.dbg_rvalid); end
        end
        7: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0010 || bus.inst !== 32'd4) begin n_err++; $display("FAIL dbg_after_gap got v=%b pc=%h inst=%h exp v=1 pc=0010 inst=4", bus.inst_valid, bus.inst_pc, bus.inst); end
        end
        default: ;
      endcase
      if (c >= 8 && c <= 11) begin
        n_cmp++; if (bus.dbg_gnt !== c[0]) begin n_err++; $display("FAIL dbg_alt_gnt c=%0d got %b exp %b", c, bus.dbg_gnt, c[0]); end
        n_cmp++; if (bus.rom_addr !== (c[0] ? 14'h1234 : 14'(7 + (c - 8) / 2))) begin
          n_err++; $display("FAIL dbg_alt_rom c=%0d got %h exp %h", c, bus.rom_addr, (c[0] ? 14'h1234 : 14'(7 + (c - 8) / 2)));
        end
      end
      if (c >= 9) begin
        n_cmp++; if (bus.dbg_rvalid !== !c[0]) begin n_err++; $display("FAIL dbg_alt_rvalid c=%0d got %b exp %b", c, bus.dbg_rvalid, !c[0]); end
      end
      next_cyc();
    end
    bus.dbg_req = 1'b0;
  endtask

  task test_wrap;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      rst = 1'b0;
      bus.inst_ready  = 1'b1;
      bus.redirect_en = (c == 3);
      bus.redirect_pc = 16'hFFFC;
      #1;
      case (c)
        3: begin
          n_cmp++; if (bus.rom_addr !== 14'h3FFF) begin n_err++; $display("FAIL wrap_rom_top got %h exp 3fff", bus.rom_addr); end
        end
        4: begin
          n_cmp++; if (bus.rom_addr !== 14'h0000 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL wrap_rom_zero got rom=%h v=%b exp rom=0 v=0", bus.rom_addr, bus.inst_valid); end
        end
        5: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'hFFFC || bus.inst !== 32'h3FFF) begin n_err++; $display("FAIL wrap_inst_top got v=%b pc=%h inst=%h exp v=1 pc=fffc inst=3fff", bus.inst_valid, bus.inst_pc, bus.inst); end
        end
        6: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0000 || bus.inst !== 32'h0) begin n_err++; $display("FAIL wrap_inst_zero got v=%b pc=%h inst=%h exp v=1 pc=0000 inst=0", bus.inst_valid, bus.inst_pc, bus.inst); end
        end
        default: ;
      endcase
      next_cyc();
    end
    bus.redirect_en = 1'b0;
  endtask

  task test_reset_mid;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      rst = (c == 5);
      bus.inst_ready = 1'b1;
      bus.dbg_req    = (c >= 3 && c <= 4);
      bus.dbg_addr   = 14'h1234;
      #1;
      case (c)
        4: begin
          n_cmp++; if (bus.dbg_gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt got %b exp 1", bus.dbg_gnt); end
        end
        5: begin
          n_cmp++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 16'h0) begin n_err++; $display("FAIL rstmid_inst got v=%b pc=%h inst=%h exp all 0", bus.inst_valid, bus.inst_pc, bus.inst); end
          n_cmp++; if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.dbg_gnt !== 1'b0) begin n_err++; $display("FAIL rstmid_dbg got rv=%b d=%h g=%b exp all 0", bus.dbg_rvalid, bus.dbg_rdata, bus.dbg_gnt); end
          n_cmp++; if (bus.rom_addr !== 14'h0) begin n_err++; $display("FAIL rstmid_rom got %h exp 0", bus.rom_addr); end
        end
        6: begin
          n_cmp++; if (bus.rom_addr !== 14'h0 || bus.dbg_rvalid !== 1'b0 || bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_restart got rom=%h rv=%b v=%b exp 0/0/0", bus.rom_addr, bus.dbg_rvalid, bus.inst_valid); end
        end
        7: begin
          n_cmp++; if (bus.rom_addr !== 14'h1) begin n_err++; $display("FAIL rstmid_rom1 got %h exp 1", bus.rom_addr); end
        end
        8: begin
          n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 16'h0 || bus.inst !== 32'h0) begin n_err++; $display("FAIL rstmid_first got v=%b pc=%h inst=%h exp v=1 pc=0 inst=0", bus.inst_valid, bus.inst_pc, bus.inst); end
        end
        default: ;
      endcase
      // Reset lands before the edge that would start the debug response.
      if (c == 4) begin
        #1;
        rst = 1'b1;
      end
      next_cyc();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_dbg();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
